// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// Holds the FSM state enum, the stats counter width and its saturating step.
package fifo_wr_arb_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker.
// Returns the one-hot first set request at or after the priority pointer.
module rr_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int P_NUM_REQ = 4,
  parameter int PTR_W     = 2
) (
  input  logic [P_NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]     i_ptr,
  output logic [P_NUM_REQ-1:0] o_gnt
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    o_gnt = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < P_NUM_REQ; i++) begin
      idx = PTR_W'((int'(i_ptr) + i) % P_NUM_REQ);
      if (!found && i_req[idx]) begin
        o_gnt[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter feeding one FIFO write port.
// Define FIFO_WR_ARB_STAT_EN to enable the saturating accepted-beat counter.
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int P_NUM_REQ   = 4,
  parameter int P_DATA_W    = 8,
  parameter int P_BURST_MAX = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [P_NUM_REQ-1:0]          i_req,
  input  logic [P_NUM_REQ*P_DATA_W-1:0] i_data,
  input  logic                          i_full,
  output logic [P_NUM_REQ-1:0]          o_ack,
  output logic [P_NUM_REQ-1:0]          o_grant,
  output logic                          o_w_en,
  output logic [P_DATA_W-1:0]           o_data,
  output logic [CNT_W-1:0]              o_wr_cnt
);

  localparam int PTR_W  = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;
  localparam int BEAT_W = $clog2(P_BURST_MAX + 1);

  state_e                 state_q, state_d;
  logic [P_NUM_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;

  logic [P_NUM_REQ-1:0]   pick;
  logic [PTR_W-1:0]       g_idx;
  logic [PTR_W-1:0]       ptr_nxt;
  logic                   req_g;
  logic                   w_en;
  logic                   last_beat;

  rr_pick #(
    .P_NUM_REQ (P_NUM_REQ),
    .PTR_W     (PTR_W)
  ) u_pick (
    .i_req (i_req),
    .i_ptr (ptr_q),
    .o_gnt (pick)
  );

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < P_NUM_REQ; i++) begin
      if (grant_q[i]) g_idx = PTR_W'(i);
    end
  end

  assign req_g   = (state_q == S_GRANT) && i_req[g_idx];
  assign ptr_nxt = (g_idx == PTR_W'(P_NUM_REQ - 1))
                 ? '0 : g_idx + PTR_W'(1);
  assign last_beat = (beat_q == BEAT_W'(P_BURST_MAX - 1));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    w_en    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        beat_d = '0;
        if (|i_req) begin
          grant_d = pick;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        w_en = req_g && !i_full;
        // a stalled beat leaves grant and count frozen
        if (!req_g || (w_en && last_beat)) begin
          state_d = S_IDLE;
          grant_d = '0;
          ptr_d   = ptr_nxt;
          beat_d  = '0;
        end else if (w_en) begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
    end
  end

  assign o_grant = grant_q;
  assign o_w_en  = w_en;
  assign o_ack   = w_en ? grant_q : '0;
  assign o_data  = (state_q == S_GRANT)
                 ? i_data[g_idx*P_DATA_W +: P_DATA_W]
                 : '0;

`ifdef FIFO_WR_ARB_STAT_EN
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (w_en) wr_cnt_d = sat_inc(wr_cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_cnt_q <= '0;
    else     wr_cnt_q <= wr_cnt_d;
  end

  assign o_wr_cnt = wr_cnt_q;
`else
  assign o_wr_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb (4 requesters, 8-bit data, burst 4).
// Works with or without FIFO_WR_ARB_STAT_EN defined.
module tb_fifo_wr_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  i_req;
  logic [31:0] i_data;
  logic        i_full;
  logic [3:0]  o_ack;
  logic [3:0]  o_grant;
  logic        o_w_en;
  logic [7:0]  o_data;
  logic [15:0] o_wr_cnt;

  int errors;
  int checks;
  int beats;

  fifo_wr_arb #(
    .P_NUM_REQ   (4),
    .P_DATA_W    (8),
    .P_BURST_MAX (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_data   (i_data),
    .i_full   (i_full),
    .o_ack    (o_ack),
    .o_grant  (o_grant),
    .o_w_en   (o_w_en),
    .o_data   (o_data),
    .o_wr_cnt (o_wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef FIFO_WR_ARB_STAT_EN
    return 32'(beats);
`else
    return 32'd0;
`endif
  endfunction

  task automatic step(input string tag,
                      input logic [3:0]  req,
                      input logic [31:0] dat,
                      input logic        full,
                      input logic [3:0]  eg,
                      input logic        ew,
                      input logic [7:0]  ed);
    i_req  = req;
    i_data = dat;
    i_full = full;
    #1;
    chk({tag, ":grant"}, 32'(o_grant), 32'(eg));
    chk({tag, ":w_en"},  32'(o_w_en),  32'(ew));
    chk({tag, ":ack"},   32'(o_ack),   32'(ew ? eg : 4'b0));
    chk({tag, ":data"},  32'(o_data),  32'(ed));
    if (ew) beats++;
    @(posedge clk);
    #1;
    chk({tag, ":cnt"}, 32'(o_wr_cnt), exp_cnt());
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    i_req  = '0;
    i_data = '0;
    i_full = 1'b0;
    beats  = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] d2(input logic [7:0] v);
    return {8'hA3, v, 8'hA1, 8'hA0};
  endfunction

  int order [5] = '{0, 1, 2, 3, 0};
  logic [31:0] fdat;

  initial begin
    errors = 0;
    checks = 0;
    fdat   = 32'h33221100;

    // reset state
    do_reset();
    chk("rst:grant", 32'(o_grant), 32'h0);
    chk("rst:w_en",  32'(o_w_en),  32'h0);
    chk("rst:cnt",   32'(o_wr_cnt), 32'h0);

    // single requester 2, six beats split 4 + 2
    step("s_arb", 4'b0100, d2(8'h10), 1'b0, 4'b0000, 1'b0, 8'h00);
    for (int b = 0; b < 4; b++)
      step("s_b", 4'b0100, d2(8'(8'h10 + b)), 1'b0,
           4'b0100, 1'b1, 8'(8'h10 + b));
    step("s_bub", 4'b0100, d2(8'h14), 1'b0, 4'b0000, 1'b0, 8'h00);
    step("s_b4", 4'b0100, d2(8'h14), 1'b0, 4'b0100, 1'b1, 8'h14);
    step("s_b5", 4'b0100, d2(8'h15), 1'b0, 4'b0100, 1'b1, 8'h15);
    step("s_rel", 4'b0000, d2(8'h16), 1'b0, 4'b0100, 1'b0, 8'h16);
    step("s_idle", 4'b0000, d2(8'h16), 1'b0, 4'b0000, 1'b0, 8'h00);

    // async reset in the middle of a burst
    step("r_arb", 4'b0001, fdat, 1'b0, 4'b0000, 1'b0, 8'h00);
    step("r_b0", 4'b0001, fdat, 1'b0, 4'b0001, 1'b1, 8'h00);
    #2;
    rst = 1'b1;
    #1;
    chk("arst:grant", 32'(o_grant), 32'h0);
    chk("arst:w_en",  32'(o_w_en),  32'h0);
    chk("arst:ack",   32'(o_ack),   32'h0);
    chk("arst:cnt",   32'(o_wr_cnt), 32'h0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    beats = 0;
    step("r_arb2", 4'b0001, fdat, 1'b0, 4'b0000, 1'b0, 8'h00);
    step("r_b1", 4'b0001, fdat, 1'b0, 4'b0001, 1'b1, 8'h00);
    step("r_rel", 4'b0000, fdat, 1'b0, 4'b0001, 1'b0, 8'h00);

    // fairness with all four requesting
    do_reset();
    foreach (order[k]) begin
      step("f_bub", 4'b1111, fdat, 1'b0, 4'b0000, 1'b0, 8'h00);
      for (int b = 0; b < 4; b++)
        step("f_b", 4'b1111, fdat, 1'b0,
             4'(1 << order[k]), 1'b1, 8'(8'h11 * order[k]));
    end

    // pointer wraps from 3 to 0
    do_reset();
    step("w_arb", 4'b1000, fdat, 1'b0, 4'b0000, 1'b0, 8'h00);
    for (int b = 0; b < 4; b++)
      step("w_b3", 4'b1000, fdat, 1'b0, 4'b1000, 1'b1, 8'h33);
    step("w_bub", 4'b1001, fdat, 1'b0, 4'b0000, 1'b0, 8'h00);
    step("w_g0", 4'b1001, fdat, 1'b0, 4'b0001, 1'b1, 8'h00);

    // full stalls requester 1 for three cycles
    do_reset();
    step("x_arb", 4'b0010, fdat, 1'b0, 4'b0000, 1'b0, 8'h00);
    step("x_b0", 4'b0010, fdat, 1'b0, 4'b0010, 1'b1, 8'h11);
    for (int c = 0; c < 3; c++)
      step("x_full", 4'b0010, fdat, 1'b1, 4'b0010, 1'b0, 8'h11);
    for (int b = 0; b < 3; b++)
      step("x_b", 4'b0010, fdat, 1'b0, 4'b0010, 1'b1, 8'h11);
    step("x_done", 4'b0000, fdat, 1'b0, 4'b0000, 1'b0, 8'h00);

    // ten accepted beats for the stats counter
    do_reset();
    step("c_arb", 4'b0001, fdat, 1'b0, 4'b0000, 1'b0, 8'h00);
    for (int b = 0; b < 4; b++)
      step("c_b", 4'b0001, fdat, 1'b0, 4'b0001, 1'b1, 8'h00);
    step("c_bub", 4'b0001, fdat, 1'b0, 4'b0000, 1'b0, 8'h00);
    for (int b = 0; b < 4; b++)
      step("c_b", 4'b0001, fdat, 1'b0, 4'b0001, 1'b1, 8'h00);
    step("c_bub", 4'b0001, fdat, 1'b0, 4'b0000, 1'b0, 8'h00);
    for (int b = 0; b < 2; b++)
      step("c_b", 4'b0001, fdat, 1'b0, 4'b0001, 1'b1, 8'h00);
    step("c_rel", 4'b0000, fdat, 1'b0, 4'b0001, 1'b0, 8'h00);
`ifdef FIFO_WR_ARB_STAT_EN
    chk("stat10", 32'(o_wr_cnt), 32'd10);
`else
    chk("stat0", 32'(o_wr_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter P_NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter P_DATA_W, default 8, data width per requester and FIFO write port.
REQ-003 SHALL have parameter P_BURST_MAX, default 4, maximum accepted beats per grant (1..16).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port i_req  input  P_NUM_REQ  per-requester write request, bit k = requester k.
REQ-007 SHALL have port i_data  input  P_NUM_REQ*P_DATA_W  flattened data, slice k = requester k.
REQ-008 SHALL have port i_full  input  1  FIFO write-side full flag.
REQ-009 SHALL have port o_ack  output  P_NUM_REQ  one-hot beat accepted, same cycle as o_w_en.
REQ-010 SHALL have port o_grant  output  P_NUM_REQ  one-hot registered current owner, 0 when idle.
REQ-011 SHALL have port o_w_en  output  1  FIFO write enable.
REQ-012 SHALL have port o_data  output  P_DATA_W  FIFO write data.
REQ-013 SHALL have port o_wr_cnt  output  16  total accepted beats (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE and GRANT.
REQ-015 IDLE: if any i_req bit set, SHALL select winner by round-robin from priority pointer, register o_grant, enter GRANT next cycle; else stay IDLE.
REQ-016 Arbitration latency SHALL be exactly 1 cycle from request sampled in IDLE to o_grant valid.
REQ-017 GRANT: o_w_en SHALL equal i_req[g] AND NOT i_full combinationally, g = granted index.
REQ-018 o_data SHALL equal i_data slice g whenever in GRANT (0 in IDLE); o_ack[g] SHALL equal o_w_en, other bits 0.
REQ-019 i_full high SHALL suppress o_w_en/o_ack and hold grant and beat count unchanged; no FIFO overflow by construction.
REQ-020 Beat counter SHALL increment on each accepted beat, clear on entry to IDLE.
REQ-021 GRANT SHALL return to IDLE when i_req[g] is low, or when an accepted beat makes count equal P_BURST_MAX.
REQ-022 On release, priority pointer SHALL move to (g+1) mod P_NUM_REQ; pointer wrap-around at P_NUM_REQ-1 -> 0.
REQ-023 Release-then-reselect SHALL cost one IDLE bubble cycle; no two requesters granted in one cycle.
REQ-024 Requests from non-granted requesters during GRANT SHALL be ignored until next IDLE.

Reset
REQ-025 rst high SHALL asynchronously force: state IDLE, o_grant 0, pointer 0, beat count 0, o_wr_cnt 0; o_w_en, o_ack, o_data therefore 0.
REQ-026 rst asserted mid-burst SHALL abort the burst with no further o_w_en; operation resumes from IDLE on first clk after deassertion.

Configuration
REQ-027 Macro FIFO_WR_ARB_STAT_EN defined: o_wr_cnt SHALL count accepted beats, saturating at 16'hFFFF.
REQ-028 Macro undefined: o_wr_cnt SHALL be tied 0, counter logic absent.

Structure
REQ-029 Package fifo_wr_arb_pkg SHALL hold the FSM state enum typedef and the counter width constant (16).
REQ-030 Sub-module rr_pick SHALL implement combinational round-robin one-hot selection from request vector and pointer.

Verification (P_NUM_REQ=4, P_BURST_MAX=4, P_DATA_W=8)
REQ-031 Reset: rst=1 mid-burst -> o_grant=0, o_w_en=0, o_wr_cnt=0 immediately, without waiting for clk.
REQ-032 Single requester: i_req=4'b0100, data 8'h10..8'h15 held 6 beats -> grant 4'b0100 after 1 cycle, 4 writes 10..13, IDLE bubble, regrant, writes 14..15.
REQ-033 Fairness: i_req=4'b1111 continuous -> grant order 0,1,2,3,0, each 4 beats, one bubble between grants.
REQ-034 Pointer wrap: grant to 3 released, i_req=4'b1001 -> next grant 0.
REQ-035 Full: i_full=1 for 3 cycles during burst by 1 -> o_w_en=0, o_ack=0, grant held, beat count frozen; burst completes 4 beats after i_full=0.
REQ-036 Stats: with FIFO_WR_ARB_STAT_EN, 10 accepted beats -> o_wr_cnt=10; without macro -> o_wr_cnt=0.
